// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions.
//   - ImmSrc format-select encodings used by the immediate generator
//   - default immediate width
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  // Format select encodings; 3'b110 and 3'b111 are illegal.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate extraction.
//   instr   : full 32-bit instruction word
//   imm_src : format select (I/S/B/U/J/Z, others illegal)
//   imm     : sign- or zero-extended immediate, XLEN wide (XLEN >= 32)
//   illegal : imm_src was not a defined format (imm forced to 0)
module imm_decode
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  // Opcode bits never feed an immediate.
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  logic [31:0] low;  // immediate as a 32-bit value
  logic        sgn;  // fill for bits above 31 when XLEN=64

  always_comb begin
    low     = '0;
    sgn     = instr[31];
    illegal = 1'b0;
    case (imm_src)
      IMM_I: low = {{20{instr[31]}}, instr[31:20]};
      IMM_S: low = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: low = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: low = {instr[31:12], 12'b0};
      IMM_J: low = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      IMM_Z: begin
        low = {27'b0, instr[19:15]};
        sgn = 1'b0;
      end
      default: begin
        sgn     = 1'b0;
        illegal = 1'b1;
      end
    endcase
    // Fill the full width with the sign, then drop in the low word; avoids a
    // zero-width replication when XLEN=32.
    imm       = {XLEN{sgn}};
    imm[31:0] = low;
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator with valid/ready handshake and a one-entry
// skid buffer.
//   clk, rst_n              : clock, async active-low reset
//   flush                   : sync flush, drops OUT and SKID entries
//   in_valid/in_ready       : input handshake; in_ready is a register
//   in_instr/in_ImmSrc      : instruction and format select
//   in_tag                  : sideband carried with the entry
//   out_valid/out_ready     : output handshake
//   out_imm/out_tag/out_illegal : registered entry
//   illegal_cnt             : saturating count of accepted illegal entries
module imm_extend_pipe
  import riscv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_ImmSrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;
  entry_t          dec, out_q, skid_q;
  logic            out_vld, skid_vld;
  logic [CNT_W-1:0] cnt;
  logic            accept;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm_src (in_ImmSrc),
    .imm     (dec_imm),
    .illegal (dec_ill)
  );

  assign dec.imm     = dec_imm;
  assign dec.tag     = in_tag;
  assign dec.illegal = dec_ill;

  // Ready depends only on skid occupancy, so there is no combinational path
  // from out_ready. A flush cycle never accepts.
  assign accept = in_valid & ~skid_vld & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!out_vld || out_ready) begin
      // OUT is free this cycle: older skid entry has priority. When skid is
      // full, accept is already 0.
      if (skid_vld) begin
        out_q    <= skid_q;
        out_vld  <= 1'b1;
        skid_vld <= 1'b0;
      end else begin
        out_vld <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      // OUT stalled: park the new entry.
      skid_q   <= dec;
      skid_vld <= 1'b1;
    end
  end

  // Counts at accept time, so entries flushed later are still counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                cnt <= '0;
    else if (accept && dec_ill && cnt != '1)   cnt <= cnt + 1'b1;
  end

  assign in_ready    = ~skid_vld;
  assign out_valid   = out_vld;
  assign out_imm     = out_q.imm;
  assign out_tag     = out_q.tag;
  assign out_illegal = out_q.illegal;
  assign illegal_cnt = cnt;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed vectors, backpressure,
// flush, counter saturation, mid-stall reset and randomized traffic checked
// against a queue-based reference model.
module tb_imm_extend_pipe;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic [2:0]       in_ImmSrc = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  imm_extend_pipe #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_ImmSrc   (in_ImmSrc),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_tag     (out_tag),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference immediate: field placement by shifts on a sign-extended word.
  function automatic logic [XLEN-1:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint sx, r;
    sx = longint'($signed(ins));
    case (src)
      3'd0: r = sx >>> 20;
      3'd1: r = ((sx >>> 25) <<< 5) | longint'(ins[11:7]);
      3'd2: r = ((sx >>> 31) <<< 12) | (longint'(ins[7]) << 11) |
                (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
      3'd3: r = (sx >>> 12) <<< 12;
      3'd4: r = ((sx >>> 31) <<< 20) | (longint'(ins[19:12]) << 12) |
                (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
      3'd5: r = longint'(ins[19:15]);
      default: r = 0;
    endcase
    return r[XLEN-1:0];
  endfunction

  // Model: the block is a FIFO of depth 2 whose head is the output.
  typedef struct {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;
  bit   acc, pop;
  ent_t e;

  // Inputs change at posedge+2, so the negedge sees both the settled DUT
  // state and the inputs that the next posedge will act on.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      mcnt = 0;
    end else begin
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("illegal_cnt", illegal_cnt, mcnt);
      if (q.size() > 0) begin
        chk("out_imm", out_imm, q[0].imm);
        chk("out_tag", out_tag, q[0].tag);
        chk("out_illegal", out_illegal, q[0].ill);
      end
      if (flush) q.delete();
      else begin
        acc = in_valid && (q.size() < 2);
        pop = (q.size() > 0) && out_ready;
        if (pop) void'(q.pop_front());
        if (acc) begin
          e.imm = ref_imm(in_instr, in_ImmSrc);
          e.tag = in_tag;
          e.ill = (in_ImmSrc > 3'd5);
          q.push_back(e);
          if (e.ill && mcnt < CMAX) mcnt++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_in_ready"}, in_ready, 1);
    chk({pfx, "_cnt"}, illegal_cnt, 0);
    chk({pfx, "_out_imm"}, out_imm, 0);
    chk({pfx, "_out_tag"}, out_tag, 0);
    chk({pfx, "_out_illegal"}, out_illegal, 0);
  endtask

  logic [31:0] d_instr [7] = '{32'hFFF00093, 32'hFE20AE23, 32'hFE000CE3,
                               32'h123452B7, 32'h001000EF, 32'h000F8000, 32'hFFFFFFFF};
  logic [2:0]  d_src   [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
  logic [31:0] d_exp   [7] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'hFFFFFFF8,
                               32'h12345000, 32'h00000800, 32'h0000001F, 32'h0};
  int  got[$];
  bit  fire_in;

  initial begin
    // Reset state
    #3;
    chk_reset_vals("rst");
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;

    // Pin the model to hand-computed values
    for (int i = 0; i < 7; i++)
      chk($sformatf("ref_vec%0d", i), ref_imm(d_instr[i], d_src[i]), d_exp[i]);
    chk("ref_illegal7", ref_imm(32'hFFFFFFFF, 3'd7), 0);

    // Directed formats, one-cycle latency
    for (int i = 0; i < 7; i++) begin
      in_valid  = 1'b1;
      in_instr  = d_instr[i];
      in_ImmSrc = d_src[i];
      in_tag    = TAG_W'(i);
      step();
      in_valid = 1'b0;
      chk($sformatf("dir_valid%0d", i), out_valid, 1);
      chk($sformatf("dir_imm%0d", i), out_imm, d_exp[i]);
    end
    chk("dir_illegal", out_illegal, 1);
    chk("dir_cnt", illegal_cnt, 1);
    step();

    // Backpressure: tags 1,2,3 with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ImmSrc = 3'd0;
    in_instr  = $urandom;
    in_tag    = 5'd1;
    step();
    chk("bp_out_tag1", out_tag, 1);
    in_tag = 5'd2;
    step();
    chk("bp_ready_low", in_ready, 0);
    in_tag = 5'd3;
    step();
    chk("bp_ready_held", in_ready, 0);
    chk("bp_head_still1", out_tag, 1);
    out_ready = 1'b1;
    got.delete();
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      fire_in = in_valid && in_ready;
      if (out_valid) got.push_back(int'(out_tag));
      step();
      if (fire_in) in_valid = 1'b0;
    end
    chk("bp_count", got.size(), 3);
    for (int i = 0; i < got.size() && i < 3; i++)
      chk($sformatf("bp_order%0d", i), got[i], i + 1);
    in_valid = 1'b0;
    step();

    // Flush with OUT and SKID full (illegal entries still count)
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ImmSrc = 3'd6;
    in_tag    = 5'd4;
    step();
    in_tag = 5'd5;
    step();
    chk("fl_full", in_ready, 0);
    chk("fl_cnt_before", illegal_cnt, 3);
    flush  = 1'b1;
    in_tag = 5'd6;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_cnt_kept", illegal_cnt, 3);
    // Flush with only OUT full: ready is high, input still not taken
    in_valid = 1'b1;
    in_tag   = 5'd7;
    step();
    chk("fl2_cnt", illegal_cnt, 4);
    flush  = 1'b1;
    in_tag = 5'd8;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", out_valid, 0);
    chk("fl2_cnt_noinc", illegal_cnt, 4);
    step();
    chk("fl2_not_accepted", out_valid, 0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_instr  = $urandom;
      in_ImmSrc = 3'($urandom_range(0, 7));
      in_tag    = TAG_W'($urandom);
      step();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();

    // Counter saturation
    in_valid  = 1'b1;
    in_ImmSrc = 3'd7;
    repeat (CMAX + 1) step();
    in_valid = 1'b0;
    step();
    chk("sat_max", illegal_cnt, CMAX);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("sat_hold", illegal_cnt, CMAX);

    // Async reset mid-stall
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ImmSrc = 3'd0;
    in_instr  = 32'hFFF00093;
    in_tag    = 5'd9;
    step();
    step();
    chk("rst2_full", in_ready, 0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst2");
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
